// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC predictor: NPC op codes, 2-bit counter
// states, the BTB entry layout and the counter saturation helper.
package npc_pkg;

    typedef enum logic [2:0] {
        NPC_PLUS4  = 3'b000,
        NPC_BRANCH = 3'b001,
        NPC_JUMP   = 3'b010,
        NPC_JALR   = 3'b100
    } npc_op_e;

    localparam logic [1:0] NPC_CTR_SNT = 2'b00;
    localparam logic [1:0] NPC_CTR_WNT = 2'b01;
    localparam logic [1:0] NPC_CTR_WT  = 2'b10;
    localparam logic [1:0] NPC_CTR_ST  = 2'b11;

    // Tag and target fields are sized for the widest supported PC; narrower
    // configurations zero-extend into them.
    localparam int NPC_MAX_W = 64;

    typedef struct packed {
        logic                 valid;
        logic [NPC_MAX_W-1:0] tag;
        logic [NPC_MAX_W-1:0] target;
        logic [1:0]           ctr;
    } npc_btb_entry_t;

    function automatic logic [1:0] npc_ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != NPC_CTR_ST) begin
                nxt = ctr + 2'd1;
            end else begin
                nxt = ctr;
            end
        end else begin
            if (ctr != NPC_CTR_SNT) begin
                nxt = ctr - 2'd1;
            end else begin
                nxt = ctr;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/npc_predict_unit_btb.sv
// Direct-mapped branch target buffer with 2-bit counters: one combinational
// read port (prediction) and one clocked write port (EX resolution).
module npc_btb
    import npc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BTB_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-3:0] rd_addr,
    output logic             rd_taken,
    output logic [WIDTH-1:0] rd_target,
    input  logic             wr_en,
    input  logic             wr_is_branch,
    input  logic             wr_taken,
    input  logic [WIDTH-3:0] wr_addr,
    input  logic [WIDTH-1:0] wr_branch_target,
    input  logic [WIDTH-1:0] wr_actual_target
);

    localparam int IDXW = $clog2(BTB_DEPTH);
    localparam int TAGW = WIDTH - IDXW - 2;

    npc_btb_entry_t mem_r [BTB_DEPTH];

    logic [IDXW-1:0] rd_idx_s;
    logic [TAGW-1:0] rd_tag_s;
    logic            rd_hit_s;
    logic [IDXW-1:0] wr_idx_s;
    logic [TAGW-1:0] wr_tag_s;
    logic            wr_hit_s;
    logic            wr_do_s;
    npc_btb_entry_t  wr_entry_s;

    assign rd_idx_s = rd_addr[IDXW-1:0];
    assign rd_tag_s = rd_addr[WIDTH-3:IDXW];
    assign wr_idx_s = wr_addr[IDXW-1:0];
    assign wr_tag_s = wr_addr[WIDTH-3:IDXW];

    // Prediction lookup; a same-cycle write is only visible after the edge.
    always_comb begin
        rd_hit_s  = mem_r[rd_idx_s].valid && (mem_r[rd_idx_s].tag == NPC_MAX_W'(rd_tag_s));
        rd_taken  = rd_hit_s && mem_r[rd_idx_s].ctr[1];
        rd_target = mem_r[rd_idx_s].target[WIDTH-1:0];
    end

    // Build the replacement entry for the resolving instruction.
    always_comb begin
        wr_hit_s   = mem_r[wr_idx_s].valid && (mem_r[wr_idx_s].tag == NPC_MAX_W'(wr_tag_s));
        wr_entry_s = mem_r[wr_idx_s];
        wr_do_s    = 1'b0;
        if (wr_hit_s) begin
            wr_do_s = 1'b1;
            if (wr_is_branch) begin
                wr_entry_s.ctr    = npc_ctr_step(mem_r[wr_idx_s].ctr, wr_taken);
                wr_entry_s.target = NPC_MAX_W'(wr_branch_target);
            end else begin
                wr_entry_s.ctr    = NPC_CTR_ST;
                wr_entry_s.target = NPC_MAX_W'(wr_actual_target);
            end
        end else if (!wr_is_branch || wr_taken) begin
            // Only taken transfers earn an entry; not-taken misses are dropped.
            wr_do_s           = 1'b1;
            wr_entry_s.valid  = 1'b1;
            wr_entry_s.tag    = NPC_MAX_W'(wr_tag_s);
            wr_entry_s.target = NPC_MAX_W'(wr_actual_target);
            wr_entry_s.ctr    = wr_is_branch ? NPC_CTR_WT : NPC_CTR_ST;
        end else begin
            wr_do_s = 1'b0;
        end
    end

    // Entry storage; reset invalidates every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en && wr_do_s) begin
            mem_r[wr_idx_s] <= wr_entry_s;
        end
    end

endmodule

// File: rtl/npc_predict_unit.sv
// Fetch PC register, BTB-based next-PC prediction and EX-stage redirect.
// Define NPC_BTB_EN to build the BTB; otherwise npc is always pc+4.
module npc_predict_unit
    import npc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter int               BTB_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] npc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic [2:0]       ex_npc_op,
    input  logic             ex_taken,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [WIDTH-1:0] ex_imm,
    input  logic [WIDTH-1:0] ex_aluout,
    input  logic [WIDTH-1:0] ex_pred_npc,
    output logic             flush
);

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_plus4_s;
    logic [WIDTH-1:0] ex_plus4_s;
    logic [WIDTH-1:0] ex_branch_target_s;
    logic [WIDTH-1:0] actual_target_s;
    logic [WIDTH-1:0] npc_s;
    logic             pred_taken_s;
    logic             flush_s;

    assign pc_plus4_s         = pc_r + WIDTH'(4);
    assign ex_plus4_s         = ex_pc + WIDTH'(4);
    assign ex_branch_target_s = ex_pc + ex_imm;

    // Resolved successor of the EX instruction; unknown op codes fall through.
    always_comb begin
        actual_target_s = ex_plus4_s;
        case (ex_npc_op)
            NPC_BRANCH: actual_target_s = ex_taken ? ex_branch_target_s : ex_plus4_s;
            NPC_JUMP:   actual_target_s = ex_branch_target_s;
            NPC_JALR:   actual_target_s = ex_aluout;
            default:    actual_target_s = ex_plus4_s;
        endcase
    end

    // Mispredict detection; held low during reset.
    always_comb begin
        if (rst) begin
            flush_s = 1'b0;
        end else begin
            flush_s = ex_valid && (actual_target_s != ex_pred_npc);
        end
    end

`ifdef NPC_BTB_EN
    logic             rd_taken_s;
    logic [WIDTH-1:0] rd_target_s;
    logic             wr_en_s;

    assign wr_en_s = ex_valid && ((ex_npc_op == NPC_BRANCH) ||
                                  (ex_npc_op == NPC_JUMP)   ||
                                  (ex_npc_op == NPC_JALR));

    npc_btb #(
        .WIDTH     (WIDTH),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk              (clk),
        .rst              (rst),
        .rd_addr          (pc_r[WIDTH-1:2]),
        .rd_taken         (rd_taken_s),
        .rd_target        (rd_target_s),
        .wr_en            (wr_en_s),
        .wr_is_branch     (ex_npc_op == NPC_BRANCH),
        .wr_taken         (ex_taken),
        .wr_addr          (ex_pc[WIDTH-1:2]),
        .wr_branch_target (ex_branch_target_s),
        .wr_actual_target (actual_target_s)
    );

    // Taken prediction overrides the sequential successor.
    always_comb begin
        if (rd_taken_s) begin
            npc_s        = rd_target_s;
            pred_taken_s = 1'b1;
        end else begin
            npc_s        = pc_plus4_s;
            pred_taken_s = 1'b0;
        end
    end
`else
    // Without a BTB every fetch is predicted sequential.
    always_comb begin
        npc_s        = pc_plus4_s;
        pred_taken_s = 1'b0;
    end
`endif

    // Fetch PC: redirect beats stall, stall beats sequential advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (flush_s) begin
            pc_r <= actual_target_s;
        end else if (stall) begin
            pc_r <= pc_r;
        end else begin
            pc_r <= npc_s;
        end
    end

    assign pc         = pc_r;
    assign npc        = npc_s;
    assign pred_taken = pred_taken_s;
    assign flush      = flush_s;

endmodule

// File: tb/tb_npc_predict_unit.sv
// Self-checking bench for npc_predict_unit: directed scenarios with literal
// expectations plus randomized EX traffic against a behavioural model.
module tb_npc_predict_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        pred_taken;
    logic        ex_valid;
    logic [2:0]  ex_npc_op;
    logic        ex_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_aluout;
    logic [31:0] ex_pred_npc;
    logic        flush;

    int errors = 0;
    int checks = 0;

    npc_predict_unit #(
        .WIDTH     (32),
        .RESET_PC  (32'h0000_0000),
        .BTB_DEPTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .pc          (pc),
        .npc         (npc),
        .pred_taken  (pred_taken),
        .ex_valid    (ex_valid),
        .ex_npc_op   (ex_npc_op),
        .ex_taken    (ex_taken),
        .ex_pc       (ex_pc),
        .ex_imm      (ex_imm),
        .ex_aluout   (ex_aluout),
        .ex_pred_npc (ex_pred_npc),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
`ifdef NPC_BTB_EN
    bit          m_v   [16];
    logic [31:0] m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_ctr [16];
`endif

    function automatic logic [31:0] m_actual();
        case (ex_npc_op)
            3'b001:  return ex_taken ? ex_pc + ex_imm : ex_pc + 32'd4;
            3'b010:  return ex_pc + ex_imm;
            3'b100:  return ex_aluout;
            default: return ex_pc + 32'd4;
        endcase
    endfunction

    task automatic m_predict(input logic [31:0] a, output logic [31:0] n, output logic t);
`ifdef NPC_BTB_EN
        int i;
        i = int'((a / 32'd4) % 32'd16);
        if (m_v[i] && m_tag[i] == a / 32'd64 && m_ctr[i] >= 2) begin
            n = m_tgt[i];
            t = 1'b1;
        end else begin
            n = a + 32'd4;
            t = 1'b0;
        end
`else
        n = a + 32'd4;
        t = 1'b0;
`endif
    endtask

    task automatic m_reset();
        m_pc = 32'h0;
`ifdef NPC_BTB_EN
        for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
`endif
    endtask

    function automatic bit m_flush();
        return !rst && ex_valid && (m_actual() != ex_pred_npc);
    endfunction

    task automatic m_advance();
        logic [31:0] n;
        logic        t;
        if (rst) begin
            m_reset();
        end else begin
            m_predict(m_pc, n, t);
`ifdef NPC_BTB_EN
            if (ex_valid && (ex_npc_op == 3'b001 || ex_npc_op == 3'b010 || ex_npc_op == 3'b100)) begin
                int  i;
                bit  hit;
                bit  isbr;
                i    = int'((ex_pc / 32'd4) % 32'd16);
                hit  = m_v[i] && m_tag[i] == ex_pc / 32'd64;
                isbr = (ex_npc_op == 3'b001);
                if (hit) begin
                    if (isbr) begin
                        m_ctr[i] = ex_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                            : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                        m_tgt[i] = ex_pc + ex_imm;
                    end else begin
                        m_ctr[i] = 3;
                        m_tgt[i] = m_actual();
                    end
                end else if (!isbr || ex_taken) begin
                    m_v[i]   = 1'b1;
                    m_tag[i] = ex_pc / 32'd64;
                    m_tgt[i] = m_actual();
                    m_ctr[i] = isbr ? 2 : 3;
                end
            end
`endif
            if (m_flush())  m_pc = m_actual();
            else if (!stall) m_pc = n;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [31:0] n;
        logic        t;
        m_predict(m_pc, n, t);
        if (rst) begin
            n = 32'h4;
            t = 1'b0;
        end
        chk("model_pc", pc, m_pc);
        chk("model_npc", npc, n);
        chk("model_pred_taken", {31'd0, pred_taken}, {31'd0, t});
        chk("model_flush", {31'd0, flush}, {31'd0, m_flush()});
    endtask

    // Compare at the falling edge, advance the model, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_model();
        m_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_go(input logic [2:0] op, input logic tk, input logic [31:0] p,
                         input logic [31:0] imm, input logic [31:0] alu, input logic [31:0] pr);
        ex_valid    = 1'b1;
        ex_npc_op   = op;
        ex_taken    = tk;
        ex_pc       = p;
        ex_imm      = imm;
        ex_aluout   = alu;
        ex_pred_npc = pr;
        #1;
    endtask

    task automatic ex_idle();
        ex_valid = 1'b0;
        ex_npc_op = 3'b000;
        ex_taken = 1'b0;
        #1;
    endtask

    logic [31:0] pc_pool [5];

    initial begin
        rst = 1'b1; stall = 1'b0;
        ex_valid = 1'b0; ex_npc_op = 3'b000; ex_taken = 1'b0;
        ex_pc = 32'h0; ex_imm = 32'h0; ex_aluout = 32'h0; ex_pred_npc = 32'h0;
        m_reset();
        pc_pool[0] = 32'h10; pc_pool[1] = 32'h50; pc_pool[2] = 32'h100;
        pc_pool[3] = 32'h200; pc_pool[4] = 32'h8;
        @(posedge clk); #1;
        tick();
        rst = 1'b0; #1;

        // Redirect to 0x40, then reset mid-run with a mismatching EX op present.
        ex_go(3'b010, 1'b0, 32'h0, 32'h40, 32'h0, 32'h4);
        chk("jump_flush", {31'd0, flush}, 32'd1);
        tick();
        chk("pc_0x40", pc, 32'h40);
        ex_go(3'b100, 1'b0, 32'h300, 32'h0, 32'h500, 32'h0);
        rst = 1'b1; #1;
        m_reset();
        chk("rst_pc", pc, 32'h0);
        chk("rst_npc", npc, 32'h4);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        tick();
        rst = 1'b0;
        ex_idle();
        tick();
        chk("step_pc4", pc, 32'h4);
        tick();
        chk("step_pc8", pc, 32'h8);

        // Stall holds for three cycles.
        stall = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", pc, 32'h8);
        end
        stall = 1'b0; #1;
        tick();
        chk("stall_release", pc, 32'hC);

        // Mispredicted taken branch redirects even while stalled.
        stall = 1'b1;
        ex_go(3'b001, 1'b1, 32'h10, 32'h20, 32'h0, 32'h14);
        chk("br_flush", {31'd0, flush}, 32'd1);
        tick();
        chk("br_redirect_pc", pc, 32'h30);

        // Learning: refetch 0x10, confirm taken, then two not-taken resolutions.
        ex_go(3'b010, 1'b0, 32'h0, 32'h10, 32'h0, 32'h4);
        tick();
        ex_idle();
        chk("refetch_pc", pc, 32'h10);
`ifdef NPC_BTB_EN
        chk("learn_npc", npc, 32'h30);
        chk("learn_pred", {31'd0, pred_taken}, 32'd1);
`else
        chk("learn_npc", npc, 32'h14);
        chk("learn_pred", {31'd0, pred_taken}, 32'd0);
`endif
        ex_go(3'b001, 1'b1, 32'h10, 32'h20, 32'h0, 32'h30);
        chk("learn_noflush", {31'd0, flush}, 32'd0);
        tick();
        ex_go(3'b001, 1'b0, 32'h10, 32'h20, 32'h0, 32'h14);
        chk("nt_noflush", {31'd0, flush}, 32'd0);
        tick();
`ifdef NPC_BTB_EN
        chk("nt1_npc", npc, 32'h30);
`endif
        tick();
        ex_idle();
        chk("nt2_npc", npc, 32'h14);
        chk("nt2_pred", {31'd0, pred_taken}, 32'd0);

        // JALR mispredict, then refetch its PC through a jump from 0x8.
        stall = 1'b0;
        ex_go(3'b100, 1'b0, 32'h100, 32'h0, 32'h200, 32'h104);
        chk("jalr_flush", {31'd0, flush}, 32'd1);
        tick();
        chk("jalr_pc", pc, 32'h200);
        ex_go(3'b010, 1'b0, 32'h8, 32'hF8, 32'h0, 32'hC);
        tick();
        ex_idle();
        stall = 1'b1; #1;
        chk("jalr_refetch_pc", pc, 32'h100);
`ifdef NPC_BTB_EN
        chk("jalr_pred_npc", npc, 32'h200);
`else
        chk("jalr_pred_npc", npc, 32'h104);
`endif

        // Wrap-around of the sequential successor.
        stall = 1'b0;
        ex_go(3'b100, 1'b0, 32'h100, 32'h0, 32'hFFFF_FFFC, 32'h104);
        tick();
        ex_idle();
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_npc", npc, 32'h0);

        // Aliasing: 0x50 shares index 4 with the taken branch at 0x10.
        stall = 1'b1;
        ex_go(3'b001, 1'b1, 32'h10, 32'h20, 32'h0, 32'h30);
        tick();
        stall = 1'b0;
        ex_go(3'b100, 1'b0, 32'h8, 32'h0, 32'h50, 32'h0);
        tick();
        ex_idle();
        chk("alias_pc", pc, 32'h50);
        chk("alias_npc", npc, 32'h54);
        chk("alias_pred", {31'd0, pred_taken}, 32'd0);

        // Randomized EX traffic.
        for (int c = 0; c < 800; c++) begin
            logic [31:0] n;
            logic        t;
            int          sel;
            int          opi;
            stall     = ($urandom_range(0, 3) == 0);
            ex_valid  = ($urandom_range(0, 9) < 7);
            opi       = $urandom_range(0, 7);
            ex_npc_op = (opi < 3) ? 3'b001 : (opi == 3) ? 3'b010 : (opi == 4) ? 3'b100
                      : (opi == 5) ? 3'b000 : 3'($urandom_range(0, 7));
            ex_taken  = $urandom_range(0, 1) == 1;
            sel       = $urandom_range(0, 5);
            ex_pc     = (sel < 5) ? pc_pool[sel] : ($urandom & 32'hFFFF_FFFC);
            ex_imm    = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 63)) * 32'd4);
            ex_aluout = ($urandom_range(0, 1) == 1) ? pc_pool[$urandom_range(0, 4)] : $urandom;
            sel       = $urandom_range(0, 2);
            m_predict(ex_pc, n, t);
            ex_pred_npc = (sel == 0) ? n : (sel == 1) ? m_actual() : $urandom;
            if (c == 400) rst = 1'b1;
            if (c == 402) rst = 1'b0;
            if (rst) m_reset();
            #1;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
